// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and the baud divider helper for the UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int   c_DATA_W   = 8;
    localparam logic c_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int den;
        int d;
        den = baud * os;
        d   = (clk_hz + den / 2) / den;
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte_if
// Description : Serial line input and received-byte outputs of uart_rx_byte.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_byte_if;

    logic                          iRX;
    logic [uart_pkg::c_DATA_W-1:0] oData;
    logic                          oValid;
    logic                          oFrameErr;
    logic                          oBusy;
    logic                          oParityErr;

    modport master (
        input  iRX,
        output oData, oValid, oFrameErr, oBusy, oParityErr
    );

    modport slave (
        output iRX,
        input  oData, oValid, oFrameErr, oBusy, oParityErr
    );

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Free-running 0..DIV-1 divider with synchronous clear; ticks on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_clear,
    output logic      o_tick
);

    localparam int c_CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_CW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == c_CW'(DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (rst || i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : Oversampling 8N1 UART receiver with held byte output and valid strobe.
//               Define UART_RX_PARITY_EN to receive an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_rx_byte_if.master  rx_if
);

    localparam int                c_DIV  = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int                c_OS_W = $clog2(OVERSAMPLE);
    localparam logic [c_OS_W-1:0] c_HALF = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0] c_LAST = c_OS_W'(OVERSAMPLE - 1);

    logic                r_rx_meta;
    logic                r_rx_s;
    rx_state_t           r_state;
    logic [c_OS_W-1:0]   r_os_cnt;
    logic [2:0]          r_idx;
    logic [c_DATA_W-1:0] r_shift;
    logic [c_DATA_W-1:0] r_data;
    logic                r_valid;
    logic                r_ferr;
    logic                r_busy;
    logic                w_tick;
    logic                w_clear;
`ifdef UART_RX_PARITY_EN
    logic                r_par_bad;
    logic                r_perr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= c_IDLE_LVL;
            r_rx_s    <= c_IDLE_LVL;
        end else begin
            r_rx_meta <= rx_if.iRX;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Divider is held at zero while idle so ticks are phase-aligned to the start edge.
    assign w_clear = (r_state == S_IDLE);

    uart_baud_tick #(.DIV(c_DIV)) u_tick (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_os_cnt  <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_HALF) begin
                            r_os_cnt <= '0;
                            r_idx    <= '0;
                            if (!r_rx_s) begin
                                r_state <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_LAST) begin
                            r_os_cnt       <= '0;
                            r_shift[r_idx] <= r_rx_s;
                            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_LAST) begin
                            r_os_cnt  <= '0;
                            r_par_bad <= r_rx_s ^ (^r_shift);
                            r_state   <= S_STOP;
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_os_cnt == c_LAST) begin
                            r_os_cnt <= '0;
                            if (r_rx_s) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                r_perr  <= r_par_bad;
`endif
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_BREAK;
                            end
                        end else begin
                            r_os_cnt <= r_os_cnt + 1'b1;
                        end
                    end
                end
                // A held-low line stays here so it yields a single framing error.
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.oData     = r_data;
    assign rx_if.oValid    = r_valid;
    assign rx_if.oFrameErr = r_ferr;
    assign rx_if.oBusy     = r_busy;
`ifdef UART_RX_PARITY_EN
    assign rx_if.oParityErr = r_perr;
`else
    assign rx_if.oParityErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_byte
// Description : Scoreboard bench for uart_rx_byte at default clock and baud settings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_byte;

    localparam int c_BIT = 432;  // 27 clk per tick * 16 ticks per bit
`ifdef UART_RX_PARITY_EN
    localparam logic c_PAR = 1'b1;
`else
    localparam logic c_PAR = 1'b0;
`endif

    typedef struct {
        logic       ferr;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_valid_cyc = 0;
    logic [7:0] exp_held = 8'h00;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_byte_if rx_if ();

    uart_rx_byte dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (rx_if)
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every strobe from the DUT consumes one scoreboard entry.
    initial begin : monitor
        exp_t e;
        logic prev_pulse;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_if.oValid && rx_if.oFrameErr) begin
                chk("valid_ferr_overlap", 1, 0);
            end else if (rx_if.oValid || rx_if.oFrameErr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind_valid", int'(rx_if.oValid), int'(!e.ferr));
                    chk("data", int'(rx_if.oData), int'(e.data));
                    chk("parity_err", int'(rx_if.oParityErr), int'(e.perr));
                    chk("pulse_one_clk", int'(prev_pulse), 0);
                end
                if (rx_if.oValid) last_valid_cyc = cyc;
            end else if (rx_if.oParityErr) begin
                chk("stray_parity_err", 1, 0);
            end
            prev_pulse = rx_if.oValid | rx_if.oFrameErr;
        end
    end

    task automatic tx_bit(input logic b);
        rx_if.iRX = b;
        repeat (c_BIT) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
        exp_t e;
        if (stop) begin
            e.ferr = 1'b0; e.data = d; e.perr = c_PAR & par_flip;
            exp_held = d;
        end else begin
            e.ferr = 1'b1; e.data = exp_held; e.perr = 1'b0;
        end
        sb.push_back(e);
        start_cyc = cyc;
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(d[i]);
        if (c_PAR) tx_bit((^d) ^ par_flip);
        tx_bit(stop);
    endtask

    task automatic idle(input int bits);
        rx_if.iRX = 1'b1;
        repeat (bits * c_BIT) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        rx_if.iRX = 1'b1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_data", int'(rx_if.oData), 0);
        chk("reset_valid", int'(rx_if.oValid), 0);
        chk("reset_ferr", int'(rx_if.oFrameErr), 0);
        chk("reset_busy", int'(rx_if.oBusy), 0);
        chk("reset_perr", int'(rx_if.oParityErr), 0);
        reset = 1'b0;
        idle(1);

        // Single frame and its latency (9.5 bit-times plus synchroniser delay).
        send(8'h4D, 1'b1, 1'b0);
        idle(1);
        if ((last_valid_cyc - start_cyc) < 4100 || (last_valid_cyc - start_cyc) > 4115)
            chk("latency_4M", last_valid_cyc - start_cyc, 4107);
        else
            chk("latency_4M", 1, 1);

        send(8'h31, 1'b1, 1'b0);
        send(8'h35, 1'b1, 1'b0);
        send(8'h41, 1'b1, 1'b0);
        idle(2);

        // 108-clk low glitch: false start
        rx_if.iRX = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_set", int'(rx_if.oBusy), 1);
        repeat (88) @(posedge clk);
        #1;
        idle(1);
        chk("glitch_busy_clear", int'(rx_if.oBusy), 0);
        chk("glitch_data_held", int'(rx_if.oData), 8'h41);

        // Stop bit low then a 3-bit-time break
        send(8'h66, 1'b0, 1'b0);
        rx_if.iRX = 1'b0;
        repeat (3 * c_BIT) @(posedge clk);
        #1;
        chk("break_busy", int'(rx_if.oBusy), 1);
        chk("break_data_held", int'(rx_if.oData), 8'h41);
        idle(2);
        chk("break_busy_clear", int'(rx_if.oBusy), 0);
        send(8'h46, 1'b1, 1'b0);
        idle(2);

        // Reset during data bit 4 of 0xFF
        tx_bit(1'b0);
        for (int i = 0; i < 4; i++) tx_bit(1'b1);
        repeat (c_BIT / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_held = 8'h00;
        idle(12);
        chk("midreset_data", int'(rx_if.oData), 0);
        chk("midreset_busy", int'(rx_if.oBusy), 0);
        send(8'h6D, 1'b1, 1'b0);
        idle(2);

        // Parity good then bad (plain 8N1 frames when parity is not built in)
        send(8'h4D, 1'b1, 1'b0);
        idle(1);
        send(8'h4D, 1'b1, 1'b1);
        idle(2);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
UART receiver stage directly upstream of the mode/command decoder in the UART_SEG_PWM_LED design. Oversamples the asynchronous serial line, deframes 8N1 characters (LSB first) and presents each received byte on a held 8-bit bus plus a one-cycle valid strobe. The decoder samples the held byte continuously, so the byte bus is stable between frames and reads 8'h00 after reset.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, serial bit rate
OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8
DIV (localparam), CLK_HZ/(BAUD*OVERSAMPLE) rounded to nearest, minimum 1; 27 with the defaults

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
iRX  input  1  asynchronous serial line; idles high
oData  output  8  last correctly framed byte, held until the next good frame
oValid  output  1  one-cycle pulse when oData is updated
oFrameErr  output  1  one-cycle pulse when the stop bit is sampled low
oBusy  output  1  high from start-edge detection until the frame ends
oParityErr  output  1  parity error pulse; tied 0 unless UART_RX_PARITY_EN is defined

Behaviour:
- Reset (synchronous, reset=1 at a clk edge) sets: oData=8'h00, oValid=0, oFrameErr=0, oBusy=0, oParityErr=0, state=IDLE, all counters=0. The synchroniser flops are set to 1.
- iRX passes through a 2-flop synchroniser before any use. rx_s is the synchronised value.
- Tick generator: a counter runs from 0 to DIV-1 and emits a tick on wrap. The counter is cleared when the FSM leaves IDLE, so sampling is phase-aligned to the start edge.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s is 0, go to START, clear the tick and sample counters, and set oBusy=1.
  - START: after OVERSAMPLE/2 ticks (bit centre), re-check rx_s. If 0, go to DATA with bit index 0. If 1, it is a false start: go to IDLE with no pulses and oBusy=0.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[idx], LSB first. After idx 7, go to STOP (or PARITY when the macro is defined).
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1: oData is loaded with shift and oValid=1 for exactly one clk, one cycle after the sample edge. Go to IDLE with oBusy=0.
    - If 0: oFrameErr=1 for one clk, oData is unchanged, and the FSM goes to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE with oBusy=0. A held-low line therefore produces exactly one oFrameErr.
- Back-to-back frames: IDLE is re-entered at mid-stop, so a start edge arriving half a bit later is caught. There is no dead time beyond one clk.
- oValid and oFrameErr are never high in the same cycle.
- Reset asserted mid-frame aborts the frame with no pulses. The remainder of the frame on the line is treated as new input. A 0 bit may appear as a start, and the false-start or framing-error rules then apply.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and samples an even-parity bit at bit centre. A mismatch with the XOR of the 8 data bits latches a flag. At the good-stop point, oParityErr pulses for one clk together with oValid, and oData is still updated.
- When undefined: there is no PARITY state, the frame is 8N1, and oParityErr is constant 0.

Decomposition:
- Package uart_pkg contains:
  - the FSM state enum (3-bit encoding);
  - localparams for the 8-bit data width and the idle line level;
  - a function computing DIV from CLK_HZ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_tick holds the divider counter with a synchronous clear input and a tick output. It is reusable by the future uart_tx.

Test Plan:
- Defaults (DIV=27): send 0x4D ('M') at 115200 -> oData=8'h4D and oValid high for exactly 1 clk, about 9.5 bit-times after the start edge. oFrameErr stays 0.
- Back-to-back 0x31, 0x35, 0x41 with no idle gap -> three oValid pulses with oData=8'h31, 8'h35, 8'h41 in order. No errors.
- Low glitch of 4 ticks (108 clk) on an idle line -> no oValid, no oFrameErr, oBusy returns to 0, oData is unchanged.
- Frame 0x66 with the stop bit driven 0, then the line held low for 3 bit-times, then high -> one oFrameErr pulse, oData keeps its prior value. The following 0x46 frame is received correctly.
- Assert reset during data bit 4 of 0xFF, release it, and leave the line idle -> oData=8'h00 and no pulses. A subsequent 0x6D is received correctly.
- With UART_RX_PARITY_EN: 0x4D with parity bit 0 -> oValid with oParityErr=0. Same byte with parity bit 1 -> oValid and oParityErr together, oData=8'h4D.
